// File: rtl/dbus_clint_if.sv
// dbus_clint_if
//   Data-bus link between the core's dbus manager and a single-cycle subordinate.
//   Requests are one-cycle pulses with no ready; read data returns one cycle later
//   and is zero whenever the subordinate is not answering, so several subordinates
//   can be ORed together.
//   Signals:
//     addr    byte address from manager
//     arvalid read request
//     wvalid  write request
//     wdata   lane-aligned write data
//     wstrb   byte enables
//     rdata   read data (subordinate -> manager)
interface dbus_clint_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] addr;
  logic            arvalid;
  logic            wvalid;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] rdata;

  modport master (
    output addr, arvalid, wvalid, wdata, wstrb,
    input  rdata
  );

  modport slave (
    input  addr, arvalid, wvalid, wdata, wstrb,
    output rdata
  );
endinterface

// File: rtl/dbus_clint.sv
// dbus_clint
//   Core-local interruptor on the data bus: msip, 64-bit mtimecmp and a
//   free-running 64-bit mtime. Drives the machine timer and software interrupt
//   lines. Fixed one-cycle read latency, no stall, rdata is zero when idle.
//   Ports:
//     clk_i    clock
//     rst_i    asynchronous active-high reset
//     dbus_if  dbus subordinate port (addr, arvalid, wvalid, wdata, wstrb, rdata)
//     mtip_o   machine timer interrupt pending (registered mtime >= mtimecmp)
//     msip_o   machine software interrupt pending
//   Optional feature:
//     REI_CLINT_PRESCALE_EN  when defined, mtime advances once every TickDiv
//                            cycles through a 16-bit prescaler.
module dbus_clint #(
  parameter logic [31:0] BaseAddr = 32'h0200_0000,
  parameter int unsigned TickDiv  = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dbus_clint_if.slave  dbus_if,
  output logic         mtip_o,
  output logic         msip_o
);

  // Word offsets (byte offset >> 2)
  localparam logic [13:0] OffMsip  = 14'h0000;
  localparam logic [13:0] OffCmpLo = 14'h1000;
  localparam logic [13:0] OffCmpHi = 14'h1001;
  localparam logic [13:0] OffTimLo = 14'h2FFE;
  localparam logic [13:0] OffTimHi = 14'h2FFF;

  logic [63:0] mtime_q, mtime_d, mtime_inc;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mtip_q, mtip_d;
  logic        tick;
  logic        sel, wr, rd;
  logic [13:0] woff;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign sel  = (dbus_if.addr[31:16] == BaseAddr[31:16]);
  assign woff = dbus_if.addr[15:2];
  assign wr   = dbus_if.wvalid && sel;
  assign rd   = dbus_if.arvalid && sel;

`ifdef REI_CLINT_PRESCALE_EN
  localparam logic [15:0] PrescLast = 16'(TickDiv - 1);
  logic [15:0] presc_q, presc_d;
  logic        tim_wr;

  assign tick   = (presc_q == PrescLast);
  assign tim_wr = wr && ((woff == OffTimLo) || (woff == OffTimHi));

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (tim_wr) presc_d = 16'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) presc_q <= 16'd0;
    else       presc_q <= presc_d;
  end
`else
  assign tick = 1'b1;
`endif

  assign mtime_inc = mtime_q + {63'd0, tick};

  always_comb begin
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr) begin
      case (woff)
        OffMsip:  if (dbus_if.wstrb[0]) msip_d = dbus_if.wdata[0];
        OffCmpLo: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  dbus_if.wdata, dbus_if.wstrb);
        OffCmpHi: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], dbus_if.wdata, dbus_if.wstrb);
        OffTimLo: begin
          mtime_d[31:0]  = merge_bytes(mtime_inc[31:0], dbus_if.wdata, dbus_if.wstrb);
          // carry out of the low half is dropped on the write cycle
          mtime_d[63:32] = mtime_q[63:32];
        end
        OffTimHi: mtime_d[63:32] = merge_bytes(mtime_inc[63:32], dbus_if.wdata, dbus_if.wstrb);
        default: ;
      endcase
    end
  end

  // Read samples pre-write state, so a same-cycle write to the word returns old data.
  always_comb begin
    rdata_d = 32'd0;
    if (rd) begin
      case (woff)
        OffMsip:  rdata_d = {31'd0, msip_q};
        OffCmpLo: rdata_d = mtimecmp_q[31:0];
        OffCmpHi: rdata_d = mtimecmp_q[63:32];
        OffTimLo: rdata_d = mtime_q[31:0];
        OffTimHi: rdata_d = mtime_q[63:32];
        default:  rdata_d = 32'd0;
      endcase
    end
  end

  assign mtip_d = (mtime_d >= mtimecmp_d);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      rdata_q    <= 32'd0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      mtip_q     <= mtip_d;
    end
  end

  assign dbus_if.rdata = rdata_q;
  assign mtip_o        = mtip_q;
  assign msip_o        = msip_q;

endmodule

// File: tb/tb_dbus_clint.sv
module tb_dbus_clint;

`ifdef REI_CLINT_PRESCALE_EN
  localparam int unsigned TICKDIV = 4;
`else
  localparam int unsigned TICKDIV = 1;
`endif
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mtip, msip;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dbus_clint_if #(.XLEN(32)) bus ();

  dbus_clint #(.BaseAddr(BASE), .TickDiv(TICKDIV)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .dbus_if (bus),
    .mtip_o  (mtip),
    .msip_o  (msip)
  );

  // Reference model state
  logic [63:0] m_time, m_cmp;
  logic        m_msip;
  int unsigned m_presc;
  logic [31:0] exp_rdata;
  logic        exp_mtip, exp_msip;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] off);
    case (off)
      16'h0000: return {31'd0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_time[31:0];
      16'hBFFC: return m_time[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_time = 64'd0; m_cmp = '1; m_msip = 1'b0; m_presc = 0;
    exp_rdata = 32'd0; exp_mtip = 1'b0; exp_msip = 1'b0;
  endtask

  // Advances the model by one clock edge with the given request.
  task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
    logic        sel, tick;
    logic [15:0] off;
    logic [63:0] nxt;
    sel = (a[31:16] == BASE[31:16]);
    off = {a[15:2], 2'b00};
    exp_rdata = (rd && sel) ? model_read(off) : 32'd0;
    tick = (m_presc == TICKDIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    nxt = m_time + (tick ? 64'd1 : 64'd0);
    if (wr && sel) begin
      case (off)
        16'h0000: if (st[0]) m_msip = wd[0];
        16'h4000: m_cmp[31:0]  = mrg(m_cmp[31:0], wd, st);
        16'h4004: m_cmp[63:32] = mrg(m_cmp[63:32], wd, st);
        16'hBFF8: begin
          nxt[31:0]  = mrg(nxt[31:0], wd, st);
          nxt[63:32] = m_time[63:32];
          m_presc = 0;
        end
        16'hBFFC: begin
          nxt[63:32] = mrg(nxt[63:32], wd, st);
          m_presc = 0;
        end
        default: ;
      endcase
    end
    m_time   = nxt;
    exp_mtip = (m_time >= m_cmp);
    exp_msip = m_msip;
  endtask

  // Drive one request for one cycle; returns at posedge+1 with outputs settled.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st);
    bus.addr = a; bus.arvalid = rd; bus.wvalid = wr; bus.wdata = wd; bus.wstrb = st;
    @(posedge clk);
    model_step(rd, wr, a, wd, st);
    #1;
    bus.arvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.addr = '0; bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rdata !== 32'd0 || mtip !== 1'b0 || msip !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h mtip=%b msip=%b required 0/0/0", bus.rdata, mtip, msip);
    end
    idle(10);
    drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL read_mtime_cycle10: rdata=%h required %h", bus.rdata, exp_rdata);
    end
`ifndef REI_CLINT_PRESCALE_EN
    checks++;
    if (bus.rdata !== 32'd10) begin
      errors++;
      $display("FAIL mtime_at_10: rdata=%0d required 10", bus.rdata);
    end
`endif
    checks++;
    if (mtip !== 1'b0 || msip !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_reset: mtip=%b msip=%b required 0/0", mtip, msip);
    end
  endtask

  task automatic test_msip();
    drive(1'b0, 1'b1, BASE, 32'd1, 4'hF);
    checks++;
    if (msip !== 1'b1) begin
      errors++;
      $display("FAIL msip_set: msip=%b required 1", msip);
    end
    drive(1'b1, 1'b0, BASE, 32'd0, 4'h0);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++;
      $display("FAIL rdata_idle: rdata=%h required 0", bus.rdata);
    end
    drive(1'b0, 1'b1, BASE, 32'hFFFF_FFFE, 4'hF);
    checks++;
    if (msip !== 1'b0 || msip !== exp_msip) begin
      errors++;
      $display("FAIL msip_clear: msip=%b required 0", msip);
    end
  endtask

  task automatic test_timer();
    bit rose;
    do_reset();
    drive(1'b0, 1'b1, BASE + 32'h4004, 32'd0, 4'hF);
    drive(1'b0, 1'b1, BASE + 32'h4000, 32'd20, 4'hF);
    rose = 1'b0;
    for (int i = 0; i < 30 * TICKDIV; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
      checks++;
      if (mtip !== exp_mtip) begin
        errors++;
        $display("FAIL mtip_track: cyc=%0d mtime=%0d mtip=%b required %b", i, m_time, mtip, exp_mtip);
      end
      if (mtip === 1'b1) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b1) begin
      errors++;
      $display("FAIL mtip_rise: mtip never rose, required rise at mtime 20");
    end
    drive(1'b0, 1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (mtip !== 1'b0) begin
      errors++;
      $display("FAIL mtip_fall: mtip=%b required 0", mtip);
    end
  endtask

  task automatic test_mtime_write();
    drive(1'b0, 1'b1, BASE + 32'hBFFC, 32'd0, 4'hF);
    drive(1'b0, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    idle(2 * TICKDIV);
    drive(1'b1, 1'b0, BASE + 32'hBFFC, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== exp_rdata || bus.rdata !== 32'd1) begin
      errors++;
      $display("FAIL mtime_carry_hi: rdata=%h required %h (1)", bus.rdata, exp_rdata);
    end
    drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL mtime_carry_lo: rdata=%h required %h", bus.rdata, exp_rdata);
    end
    // 64-bit wrap: load all ones, then watch it roll to zero
    drive(1'b0, 1'b1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    drive(1'b0, 1'b1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 2 * TICKDIV + 1; i++) begin
      drive(1'b1, 1'b0, BASE + ((i % 2 == 0) ? 32'hBFFC : 32'hBFF8), 32'd0, 4'h0);
      checks++;
      if (bus.rdata !== exp_rdata || mtip !== exp_mtip) begin
        errors++;
        $display("FAIL mtime_wrap: step=%0d rdata=%h mtip=%b required %h %b", i, bus.rdata, mtip, exp_rdata, exp_mtip);
      end
    end
  endtask

  task automatic test_byte_write();
    do_reset();
    drive(1'b0, 1'b1, BASE + 32'h4000, 32'h0000_AB00, 4'b0010);
    drive(1'b1, 1'b0, BASE + 32'h4000, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== 32'hFFFF_ABFF || bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL cmp_byte_write: rdata=%h required FFFFABFF", bus.rdata);
    end
    // same-cycle read and write of one word: old data returned, write lands
    drive(1'b1, 1'b1, BASE + 32'h4004, 32'h1234_5678, 4'hF);
    checks++;
    if (bus.rdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rw_same_word_old: rdata=%h required FFFFFFFF", bus.rdata);
    end
    drive(1'b1, 1'b0, BASE + 32'h4004, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rw_same_word_new: rdata=%h required 12345678", bus.rdata);
    end
  endtask

  task automatic test_unmapped();
    drive(1'b1, 1'b0, BASE + 32'h1000, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read: rdata=%h required 0", bus.rdata);
    end
    drive(1'b1, 1'b0, 32'h0300_BFF8, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== 32'd0) begin
      errors++;
      $display("FAIL outside_window: rdata=%h required 0", bus.rdata);
    end
    drive(1'b0, 1'b1, 32'h0300_0000, 32'd1, 4'hF);
    checks++;
    if (msip !== 1'b0) begin
      errors++;
      $display("FAIL outside_write: msip=%b required 0", msip);
    end
  endtask

  task automatic test_reset_midread();
    drive(1'b0, 1'b1, BASE, 32'd1, 4'hF);
    drive(1'b0, 1'b1, BASE + 32'hBFF8, 32'hDEAD_BEEF, 4'hF);
    drive(1'b1, 1'b0, BASE + 32'hBFF8, 32'd0, 4'h0);
    checks++;
    if (bus.rdata !== exp_rdata) begin
      errors++;
      $display("FAIL pre_reset_read: rdata=%h required %h", bus.rdata, exp_rdata);
    end
    bus.arvalid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.rdata !== 32'd0 || msip !== 1'b0 || mtip !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdata=%h msip=%b mtip=%b required 0/0/0", bus.rdata, msip, mtip);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [15:0] offs [7] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1000, 16'h0008};
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, wd;
      logic [3:0]  st;
      logic        rd, wr;
      a  = {(($urandom_range(0, 7) == 0) ? 16'h0201 : BASE[31:16]), offs[$urandom_range(0, 6)]};
      a[1:0] = 2'($urandom);
      rd = 1'($urandom);
      wr = ($urandom_range(0, 3) == 0);
      st = 4'($urandom);
      wd = $urandom;
      // keep mtime mostly near mtimecmp so compare flips are exercised
      if (wr && a[15:0] >= 16'hBFF8 && $urandom_range(0, 1) == 1) wd = m_cmp[31:0] ^ 32'(i % 3);
      drive(rd, wr, a, wd, st);
      checks++;
      if (bus.rdata !== exp_rdata || mtip !== exp_mtip || msip !== exp_msip) begin
        errors++;
        $display("FAIL random_op: i=%0d addr=%h rdata=%h mtip=%b msip=%b required %h %b %b",
                 i, a, bus.rdata, mtip, msip, exp_rdata, exp_mtip, exp_msip);
      end
    end
  endtask

  initial begin
    bus.addr = '0; bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    model_reset();
    test_reset();
    test_msip();
    test_timer();
    test_mtime_write();
    test_byte_write();
    test_unmapped();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
